// File: rtl/regfile_wb_buffer_pkg.sv
// regfile_wb_buffer_pkg: widths shared with the register file (rf_defs) plus pointer sizing helper
package regfile_wb_buffer_pkg;
    localparam int RF_BW_DATA = 32;
    localparam int RF_BW_ADDR = 5;
    localparam int WB_DEPTH   = 4;
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/regfile_wb_buffer_if.sv
// regfile_wb_buffer_if: write request, register file write port, forwarding ports and occupancy
interface regfile_wb_buffer_if import regfile_wb_buffer_pkg::*; #(
    parameter int BW_DATA = RF_BW_DATA,
    parameter int BW_ADDR = RF_BW_ADDR,
    parameter int DEPTH   = WB_DEPTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BW_ADDR-1:0]     in_addr;
    logic [BW_DATA-1:0]     in_data;
    logic                   wr_stall;
    logic                   wen;
    logic [BW_ADDR-1:0]     wr_addr;
    logic [BW_DATA-1:0]     wr_data;
    logic [BW_ADDR-1:0]     rd_addr0;
    logic [BW_ADDR-1:0]     rd_addr1;
    logic                   fwd_hit0;
    logic [BW_DATA-1:0]     fwd_data0;
    logic                   fwd_hit1;
    logic [BW_DATA-1:0]     fwd_data1;
    logic [ptr_w(DEPTH):0]  count;
    modport master (
        output in_valid, in_addr, in_data, wr_stall, rd_addr0, rd_addr1,
        input  in_ready, wen, wr_addr, wr_data, fwd_hit0, fwd_data0, fwd_hit1, fwd_data1, count
    );
    modport slave (
        input  in_valid, in_addr, in_data, wr_stall, rd_addr0, rd_addr1,
        output in_ready, wen, wr_addr, wr_data, fwd_hit0, fwd_data0, fwd_hit1, fwd_data1, count
    );
endinterface

// File: rtl/regfile_wb_buffer_wb_queue.sv
// wb_queue: circular buffer of pending register writes with per-entry valid bits
module wb_queue import regfile_wb_buffer_pkg::*; #(
    parameter int BW_DATA = RF_BW_DATA,
    parameter int BW_ADDR = RF_BW_ADDR,
    parameter int DEPTH   = WB_DEPTH,
    localparam int PW     = ptr_w(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [BW_ADDR-1:0]              push_addr,
    input  logic [BW_DATA-1:0]              push_data,
    output logic [BW_ADDR-1:0]              head_addr,
    output logic [BW_DATA-1:0]              head_data,
    output logic [DEPTH-1:0][BW_ADDR-1:0]   ent_addr,
    output logic [DEPTH-1:0][BW_DATA-1:0]   ent_data,
    output logic [DEPTH-1:0]                ent_vld,
    output logic [PW-1:0]                   wr_ptr,
    output logic [PW:0]                     count
);
    logic [DEPTH-1:0][BW_ADDR-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][BW_DATA-1:0] data_q, data_d;
    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                   count_q, count_d;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // payload is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign ent_addr  = addr_q;
    assign ent_data  = data_q;
    assign ent_vld   = vld_q;
    assign wr_ptr    = wr_ptr_q;
    assign count     = count_q;
endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: write-back queue in front of the 2R/1W register file with read forwarding
module regfile_wb_buffer import regfile_wb_buffer_pkg::*; #(
    parameter int BW_DATA     = RF_BW_DATA,
    parameter int BW_ADDR     = RF_BW_ADDR,
    parameter int DEPTH       = WB_DEPTH,
    parameter bit ZERO_REG_EN = 1'b1,
    localparam int PW         = ptr_w(DEPTH)
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_buffer_if.slave  bus
);
    logic                          push, pop, full, drop;
    logic [BW_ADDR-1:0]            head_addr;
    logic [BW_DATA-1:0]            head_data;
    logic [DEPTH-1:0][BW_ADDR-1:0] ent_addr;
    logic [DEPTH-1:0][BW_DATA-1:0] ent_data;
    logic [DEPTH-1:0]              ent_vld;
    logic [PW-1:0]                 wr_ptr;
    logic [PW:0]                   count;
    logic [DEPTH-1:0][PW-1:0]      age_idx;
    logic                          hit0, hit1;
    logic [BW_DATA-1:0]            data0, data1;

    // count never exceeds DEPTH (a power of two), so its top bit alone means full
    assign full         = count[PW];
    assign drop         = ZERO_REG_EN && (bus.in_addr == '0);
    assign bus.in_ready = !rst && !full;
    assign push         = bus.in_valid && bus.in_ready && !drop;
    assign pop          = (count != '0) && !bus.wr_stall;
    assign bus.wen      = pop;
    assign bus.wr_addr  = head_addr;
    assign bus.wr_data  = head_data;
    assign bus.count    = count;

    wb_queue #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (bus.in_addr),
        .push_data (bus.in_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_vld   (ent_vld),
        .wr_ptr    (wr_ptr),
        .count     (count)
    );

    // age_idx[0] is the youngest slot, age_idx[DEPTH-1] the oldest
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign age_idx[g] = wr_ptr - PW'(g + 1);
    end

    // scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        hit0  = 1'b0;
        data0 = '0;
        hit1  = 1'b0;
        data1 = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_vld[age_idx[i]] && ent_addr[age_idx[i]] == bus.rd_addr0) begin
                hit0  = 1'b1;
                data0 = ent_data[age_idx[i]];
            end
            if (ent_vld[age_idx[i]] && ent_addr[age_idx[i]] == bus.rd_addr1) begin
                hit1  = 1'b1;
                data1 = ent_data[age_idx[i]];
            end
        end
        if (ZERO_REG_EN && bus.rd_addr0 == '0) begin
            hit0  = 1'b0;
            data0 = '0;
        end
        if (ZERO_REG_EN && bus.rd_addr1 == '0) begin
            hit1  = 1'b0;
            data1 = '0;
        end
    end

    assign bus.fwd_hit0  = hit0;
    assign bus.fwd_data0 = data0;
    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_data1 = data1;
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// tb_regfile_wb_buffer: directed and random checks of the write-back queue against a queue model
module tb_regfile_wb_buffer;
    localparam int BD = 32;
    localparam int BA = 5;
    localparam int D  = 4;

    typedef struct {
        logic [BA-1:0] a;
        logic [BD-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_buffer_if #(.BW_DATA(BD), .BW_ADDR(BA), .DEPTH(D)) bus_a ();
    regfile_wb_buffer_if #(.BW_DATA(BD), .BW_ADDR(BA), .DEPTH(D)) bus_b ();

    regfile_wb_buffer #(.BW_DATA(BD), .BW_ADDR(BA), .DEPTH(D), .ZERO_REG_EN(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );
    regfile_wb_buffer #(.BW_DATA(BD), .BW_ADDR(BA), .DEPTH(D), .ZERO_REG_EN(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    ent_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [BD-1:0] rf [32];
    logic          seen_bad = 1'b0;
    logic          acc;

    // register file image built from what dut_a actually writes
    always @(posedge clk) begin
        if (bus_a.wen) begin
            rf[bus_a.wr_addr] <= bus_a.wr_data;
            if (bus_a.wr_addr inside {5'd11, 5'd12, 5'd13}) seen_bad <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // youngest queued write to r, register 0 never forwards on dut_a
    function automatic logic [BD:0] model_fwd(input logic [BA-1:0] r);
        logic [BD:0] res = '0;
        if (r == '0) return res;
        foreach (q[i]) if (q[i].a == r) res = {1'b1, q[i].d};
        return res;
    endfunction

    task automatic cycle(input logic v, input logic [BA-1:0] a, input logic [BD-1:0] d,
                         input logic st, input logic [BA-1:0] r0, input logic [BA-1:0] r1,
                         output logic accepted);
        logic        rdy, pop;
        logic [BD:0] f0, f1;
        bus_a.in_valid = v;
        bus_a.in_addr  = a;
        bus_a.in_data  = d;
        bus_a.wr_stall = st;
        bus_a.rd_addr0 = r0;
        bus_a.rd_addr1 = r1;
        rdy      = q.size() < D;
        pop      = (q.size() > 0) && !st;
        accepted = v && rdy;
        f0       = model_fwd(r0);
        f1       = model_fwd(r1);
        #3;
        check("count", 64'(bus_a.count), 64'(q.size()));
        check("in_ready", 64'(bus_a.in_ready), 64'(rdy));
        check("wen", 64'(bus_a.wen), 64'(pop));
        if (pop) begin
            check("wr_addr", 64'(bus_a.wr_addr), 64'(q[0].a));
            check("wr_data", 64'(bus_a.wr_data), 64'(q[0].d));
        end
        check("fwd_hit0", 64'(bus_a.fwd_hit0), 64'(f0[BD]));
        check("fwd_data0", 64'(bus_a.fwd_data0), 64'(f0[BD-1:0]));
        check("fwd_hit1", 64'(bus_a.fwd_hit1), 64'(f1[BD]));
        check("fwd_data1", 64'(bus_a.fwd_data1), 64'(f1[BD-1:0]));
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (accepted && a != '0) q.push_back('{a: a, d: d});
    endtask

    task automatic drain();
        logic dummy;
        for (int n = 0; n < 20 && q.size() > 0; n++) cycle(1'b0, '0, '0, 1'b0, '0, '0, dummy);
        check("drained", 64'(bus_a.count), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus_a.in_valid = 1'b0; bus_a.in_addr = '0; bus_a.in_data = '0;
        bus_a.wr_stall = 1'b0; bus_a.rd_addr0 = '0; bus_a.rd_addr1 = '0;
        bus_b.in_valid = 1'b0; bus_b.in_addr = '0; bus_b.in_data = '0;
        bus_b.wr_stall = 1'b0; bus_b.rd_addr0 = '0; bus_b.rd_addr1 = '0;
        #2;
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("rst_wen", 64'(bus_a.wen), 64'd0);
        check("rst_count", 64'(bus_a.count), 64'd0);
        check("rst_fwd_hit1", 64'(bus_a.fwd_hit1), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2 check("rel_in_ready", 64'(bus_a.in_ready), 64'd1);

        // reset with three writes pending
        cycle(1'b1, 5'd11, 32'h1111, 1'b1, 5'd11, 5'd12, acc);
        cycle(1'b1, 5'd12, 32'h1212, 1'b1, 5'd11, 5'd12, acc);
        cycle(1'b1, 5'd13, 32'h1313, 1'b1, 5'd13, 5'd12, acc);
        bus_a.in_valid = 1'b0;
        bus_a.wr_stall = 1'b0;
        bus_a.rd_addr0 = 5'd11;
        #2;
        check("pre_rst_wen", 64'(bus_a.wen), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_wen", 64'(bus_a.wen), 64'd0);
        check("async_rst_count", 64'(bus_a.count), 64'd0);
        check("async_rst_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("async_rst_fwd_hit0", 64'(bus_a.fwd_hit0), 64'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // single write, one-cycle latency into the array
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, acc);
        check("rf5", 64'(rf[5]), 64'hDEADBEEF);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, acc);

        // fill under stall, fifth request held until space appears
        for (int i = 1; i <= 4; i++) cycle(1'b1, BA'(i), BD'(32'h300 + i), 1'b1, BA'(i), 5'd1, acc);
        cycle(1'b1, 5'd5, 32'h305, 1'b1, 5'd4, 5'd2, acc);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cycle(1'b1, 5'd5, 32'h305, 1'b0, 5'd3, 5'd5, acc);
            n++;
        end
        check("fifth_latency", 64'(n), 64'd2);
        drain();

        // youngest of two writes to the same register wins
        cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 5'd8, acc);
        cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd8, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd8, acc);
        drain();

        // register 0 dropped on dut_a, queued on dut_b
        cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, acc);
        check("zero_dropped_count", 64'(bus_a.count), 64'd0);
        bus_b.in_valid = 1'b1;
        bus_b.in_addr  = 5'd0;
        bus_b.in_data  = 32'hFFFF;
        #3;
        check("b_in_ready", 64'(bus_b.in_ready), 64'd1);
        @(posedge clk);
        #1 bus_b.in_valid = 1'b0;
        #2;
        check("b_count", 64'(bus_b.count), 64'd1);
        check("b_wen", 64'(bus_b.wen), 64'd1);
        check("b_wr_addr", 64'(bus_b.wr_addr), 64'd0);
        check("b_wr_data", 64'(bus_b.wr_data), 64'hFFFF);
        check("b_fwd_hit0", 64'(bus_b.fwd_hit0), 64'd1);
        check("b_fwd_data0", 64'(bus_b.fwd_data0), 64'hFFFF);
        @(posedge clk);
        #1;
        check("b_count_after", 64'(bus_b.count), 64'd0);
        check("b_wen_after", 64'(bus_b.wen), 64'd0);

        // random traffic with stalls, wraparound and push+pop
        repeat (1000) begin
            cycle($urandom_range(0, 2) != 0, BA'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, BA'($urandom_range(0, 7)), BA'($urandom_range(0, 7)), acc);
        end
        drain();
        check("discarded_never_written", 64'(seen_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
